// File: rtl/prpg_pkg.sv
// rtl/prpg_pkg.sv - shared types and constants for the PRPG batch sequencer
package prpg_pkg;

    typedef logic [7:0] pattern_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CONFIG = 3'd1,
        ST_SEED   = 3'd2,
        ST_STEP   = 3'd3,
        ST_STORE  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Engine select encoding carried on cmd_eng / eng_sel.
    localparam logic ENG_LFSR = 1'b0;
    localparam logic ENG_CA   = 1'b1;

    // Opcodes shared with the instruction decoder.
    localparam logic [3:0] OP_NOP      = 4'h0;
    localparam logic [3:0] OP_RUN      = 4'h1;
    localparam logic [3:0] OP_STORE    = 4'h2;
    localparam logic [3:0] OP_ADD_ADDR = 4'h3;
    localparam logic [3:0] OP_BATCH    = 4'h4;

endpackage

// File: rtl/prpg_batch_sequencer_popcount8.sv
// rtl/prpg_batch_sequencer_popcount8.sv - combinational 8-bit population count
//
// Ports:
//   data_i  : 8-bit input word
//   count_o : number of set bits in data_i (0..8)
module popcount8
    import prpg_pkg::*;
(
    input  pattern_t     data_i,
    output logic [3:0]   count_o
);

    always_comb begin
        count_o = 4'd0;
        for (int i = 0; i < 8; i++) begin
            count_o = count_o + {3'b000, data_i[i]};
        end
    end

endmodule

// File: rtl/prpg_batch_sequencer.sv
// rtl/prpg_batch_sequencer.sv - batch command sequencer for the LFSR/CA pattern engines
//
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     : batch command handshake (ready only when idle)
//   cmd_eng/cfg/seed/addr/count : batch fields captured on accept
//   abort                   : end the running batch early
//   eng_sel, eng_cfg_we, eng_seed_we, eng_step, eng_cfg_data, eng_seed_data : engine control
//   eng_q                   : current engine pattern
//   mem_we/mem_addr/mem_wdata : pattern memory write port
//   busy, done, err, hd_sum : status
module prpg_batch_sequencer
    import prpg_pkg::*;
#(
    parameter int MEM_DEPTH = 251,
    parameter int HD_W      = 11
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_eng,
    input  logic [7:0]      cmd_cfg,
    input  logic [7:0]      cmd_seed,
    input  logic [7:0]      cmd_addr,
    input  logic [7:0]      cmd_count,
    input  logic            abort,
    output logic            eng_sel,
    output logic            eng_cfg_we,
    output logic            eng_seed_we,
    output logic            eng_step,
    output logic [7:0]      eng_cfg_data,
    output logic [7:0]      eng_seed_data,
    input  logic [7:0]      eng_q,
    output logic            mem_we,
    output logic [7:0]      mem_addr,
    output logic [7:0]      mem_wdata,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [HD_W-1:0] hd_sum
);

    localparam logic [8:0] DEPTH_LIM = 9'(MEM_DEPTH);

    state_t          state_q, state_d;
    logic            sel_q, sel_d;
    pattern_t        cfg_q, cfg_d;
    pattern_t        seed_q, seed_d;
    pattern_t        prev_q, prev_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [HD_W-1:0] hd_q, hd_d;

    logic [3:0]      diff_bits;
    logic            addr_ok;

    popcount8 u_popcount8 (
        .data_i  (eng_q ^ prev_q),
        .count_o (diff_bits)
    );

    assign addr_ok = ({1'b0, addr_q} < DEPTH_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= 1'b0;
            cfg_q   <= '0;
            seed_q  <= '0;
            prev_q  <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            hd_q    <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cfg_q   <= cfg_d;
            seed_q  <= seed_d;
            prev_q  <= prev_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            hd_q    <= hd_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cfg_d       = cfg_q;
        seed_d      = seed_q;
        prev_d      = prev_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        hd_d        = hd_q;
        cmd_ready   = 1'b0;
        eng_cfg_we  = 1'b0;
        eng_seed_we = 1'b0;
        eng_step    = 1'b0;
        mem_we      = 1'b0;
        mem_wdata   = 8'h00;
        done        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    sel_d   = cmd_eng;
                    cfg_d   = cmd_cfg;
                    seed_d  = cmd_seed;
                    addr_d  = cmd_addr;
                    cnt_d   = cmd_count;
                    err_d   = 1'b0;
                    hd_d    = '0;
                    state_d = ST_CONFIG;
                end
            end
            ST_CONFIG: begin
                eng_cfg_we = 1'b1;
                state_d    = abort ? ST_DONE : ST_SEED;
            end
            ST_SEED: begin
                eng_seed_we = 1'b1;
                prev_d      = seed_q;
                state_d     = (abort || cnt_q == 8'd0) ? ST_DONE : ST_STEP;
            end
            ST_STEP: begin
                eng_step = 1'b1;
                state_d  = abort ? ST_DONE : ST_STORE;
            end
            ST_STORE: begin
                // The write (or its suppression) always completes, even under abort.
                mem_wdata = eng_q;
                mem_we    = addr_ok;
                if (!addr_ok) begin
                    err_d = 1'b1;
                end
                hd_d    = hd_q + HD_W'(diff_bits);
                prev_d  = eng_q;
                addr_d  = addr_q + 8'd1;
                cnt_d   = cnt_q - 8'd1;
                state_d = (abort || cnt_d == 8'd0) ? ST_DONE : ST_STEP;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign eng_sel       = sel_q;
    assign eng_cfg_data  = cfg_q;
    assign eng_seed_data = seed_q;
    assign mem_addr      = addr_q;
    assign busy          = (state_q != ST_IDLE);
    assign err           = err_q;
    assign hd_sum        = hd_q;

endmodule

// File: tb/tb_prpg_batch_sequencer.sv
// tb/tb_prpg_batch_sequencer.sv - self-checking bench for prpg_batch_sequencer
module tb_prpg_batch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_eng = 1'b0;
    logic [7:0]  cmd_cfg = 8'h00;
    logic [7:0]  cmd_seed = 8'h00;
    logic [7:0]  cmd_addr = 8'h00;
    logic [7:0]  cmd_count = 8'h00;
    logic        abort = 1'b0;
    logic [7:0]  eng_q = 8'h00;
    logic        cmd_ready, eng_sel, eng_cfg_we, eng_seed_we, eng_step;
    logic [7:0]  eng_cfg_data, eng_seed_data, mem_addr, mem_wdata;
    logic        mem_we, busy, done, err;
    logic [10:0] hd_sum;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    prpg_batch_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_eng       (cmd_eng),
        .cmd_cfg       (cmd_cfg),
        .cmd_seed      (cmd_seed),
        .cmd_addr      (cmd_addr),
        .cmd_count     (cmd_count),
        .abort         (abort),
        .eng_sel       (eng_sel),
        .eng_cfg_we    (eng_cfg_we),
        .eng_seed_we   (eng_seed_we),
        .eng_step      (eng_step),
        .eng_cfg_data  (eng_cfg_data),
        .eng_seed_data (eng_seed_data),
        .eng_q         (eng_q),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .hd_sum        (hd_sum)
    );

    // Stub engine: seed load restarts the table, each step presents the next entry.
    logic [7:0] stub_tbl [0:7];
    int         stub_idx = 0;

    always @(posedge clk) begin
        if (eng_seed_we) begin
            eng_q    <= eng_seed_data;
            stub_idx <= 0;
        end else if (eng_step) begin
            eng_q    <= stub_tbl[stub_idx];
            stub_idx <= stub_idx + 1;
        end
    end

    logic [7:0]  mem [0:255];
    logic [15:0] exp_wr [$];
    int          writes_seen = 0;
    int          cfg_seen = 0;
    int          seed_seen = 0;
    int          step_seen = 0;
    logic        exp_eng = 1'b0;
    logic [7:0]  exp_cfg = 8'h00;
    logic [7:0]  exp_seed = 8'h00;

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("strobe_exclusive",
                  int'(eng_cfg_we) + int'(eng_seed_we) + int'(eng_step) + int'(mem_we), -1 + 1 +
                  ((int'(eng_cfg_we) + int'(eng_seed_we) + int'(eng_step) + int'(mem_we)) > 1 ? 1 :
                   (int'(eng_cfg_we) + int'(eng_seed_we) + int'(eng_step) + int'(mem_we))) -
                  ((int'(eng_cfg_we) + int'(eng_seed_we) + int'(eng_step) + int'(mem_we)) > 1 ? 0 : 0));
            check("ready_vs_busy", int'(cmd_ready), int'(!busy));
            if (busy) check("eng_sel", int'(eng_sel), int'(exp_eng));
            if (eng_cfg_we) begin
                cfg_seen <= cfg_seen + 1;
                check("cfg_data", int'(eng_cfg_data), int'(exp_cfg));
            end
            if (eng_seed_we) begin
                seed_seen <= seed_seen + 1;
                check("seed_data", int'(eng_seed_data), int'(exp_seed));
            end
            if (eng_step) step_seen <= step_seen + 1;
            if (mem_we) begin
                writes_seen <= writes_seen + 1;
                mem[mem_addr] <= mem_wdata;
                if (exp_wr.size() == 0) begin
                    check("unexpected_write_addr", int'(mem_addr), -1);
                end else begin
                    check("wr_addr", int'(mem_addr), int'(exp_wr[0][15:8]));
                    check("wr_data", int'(mem_wdata), int'(exp_wr[0][7:0]));
                    void'(exp_wr.pop_front());
                end
            end
        end
    end

    // Model: from the command and the stub table, derive writes, hd, err and latency.
    task automatic run_batch(input string tag, input logic eng, input logic [7:0] cfg,
                             input logic [7:0] seed, input logic [7:0] addr,
                             input logic [7:0] count, input int abort_step, output int lat);
        int         n;
        int         hd;
        int         e;
        int         exp_lat;
        int         c0, s0, t0;
        logic [7:0] prev;
        logic [7:0] a;
        n = (abort_step > 0) ? abort_step - 1 : int'(count);
        hd = 0;
        e = 0;
        prev = seed;
        for (int i = 0; i < n; i++) begin
            a = addr + 8'(i);
            if (a < 8'd251) exp_wr.push_back({a, stub_tbl[i]});
            else e = 1;
            hd += $countones(prev ^ stub_tbl[i]);
            prev = stub_tbl[i];
        end
        exp_lat = 3 + 2 * n + ((abort_step > 0) ? 1 : 0);
        exp_eng = eng;
        exp_cfg = cfg;
        exp_seed = seed;
        c0 = cfg_seen;
        s0 = seed_seen;
        t0 = step_seen;

        @(posedge clk); #1;
        check({tag, "_ready_before"}, int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_eng = eng;
        cmd_cfg = cfg;
        cmd_seed = seed;
        cmd_addr = addr;
        cmd_count = count;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!done && lat < 600) begin
            abort = (abort_step > 0) && (lat == 3 + 2 * (abort_step - 1));
            @(posedge clk); #1;
            lat++;
        end
        abort = 1'b0;
        check({tag, "_done_seen"}, int'(done), 1);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_hd_sum"}, int'(hd_sum), hd);
        check({tag, "_err"}, int'(err), e);
        check({tag, "_writes_left"}, exp_wr.size(), 0);
        check({tag, "_cfg_strobes"}, cfg_seen - c0, 1);
        check({tag, "_seed_strobes"}, seed_seen - s0, 1);
        check({tag, "_step_strobes"}, step_seen - t0, n + ((abort_step > 0) ? 1 : 0));
        exp_wr.delete();
        @(posedge clk); #1;
        check({tag, "_done_one_cycle"}, int'(done), 0);
        check({tag, "_idle_ready"}, int'(cmd_ready), 1);
        check({tag, "_idle_busy"}, int'(busy), 0);
    endtask

    int lat;
    int w0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) stub_tbl[i] = 8'h00;

        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_hd", int'(hd_sum), 0);
        check("rst_mem_we", int'(mem_we), 0);
        check("rst_eng_sel", int'(eng_sel), 0);
        check("rst_strobes", int'(eng_cfg_we) + int'(eng_seed_we) + int'(eng_step), 0);
        #12 rst_n = 1'b1;

        // CA batch from the plan.
        stub_tbl[0] = 8'h01; stub_tbl[1] = 8'h03; stub_tbl[2] = 8'h07;
        run_batch("ca", 1'b1, 8'h1E, 8'h10, 8'd240, 8'd3, 0, lat);
        check("ca_lat_lit", lat, 9);
        check("ca_m240_lit", int'(mem[240]), 8'h01);
        check("ca_m241_lit", int'(mem[241]), 8'h03);
        check("ca_m242_lit", int'(mem[242]), 8'h07);
        check("ca_hd_lit", int'(hd_sum), 4);
        check("ca_err_lit", int'(err), 0);

        // Address boundary: 249, 250 written; 251, 252 suppressed.
        for (int i = 0; i < 8; i++) stub_tbl[i] = 8'hFF;
        run_batch("bound", 1'b0, 8'h5B, 8'h0F, 8'd249, 8'd4, 0, lat);
        check("bound_m249_lit", int'(mem[249]), 8'hFF);
        check("bound_m250_lit", int'(mem[250]), 8'hFF);
        check("bound_err_lit", int'(err), 1);
        check("bound_hd_lit", int'(hd_sum), 4);

        // count=0 with LFSR: err and hd clear on accept.
        run_batch("zero", 1'b0, 8'h47, 8'hA5, 8'd7, 8'd0, 0, lat);
        check("zero_lat_lit", lat, 3);
        check("zero_hd_lit", int'(hd_sum), 0);
        check("zero_err_lit", int'(err), 0);

        // Wrap: 255 suppressed, then 0 written.
        stub_tbl[0] = 8'h5A; stub_tbl[1] = 8'hA5;
        run_batch("wrap", 1'b1, 8'h96, 8'h00, 8'hFF, 8'd2, 0, lat);
        check("wrap_m0_lit", int'(mem[0]), 8'hA5);
        check("wrap_err_lit", int'(err), 1);
        check("wrap_hd_lit", int'(hd_sum), 12);

        // Abort in the second STEP of a count=5 batch.
        for (int i = 0; i < 8; i++) stub_tbl[i] = 8'(8'h11 * (i + 1));
        w0 = writes_seen;
        run_batch("abort", 1'b0, 8'h21, 8'h33, 8'd20, 8'd5, 2, lat);
        check("abort_lat_lit", lat, 6);
        check("abort_writes_lit", writes_seen - w0, 1);
        check("abort_m20_lit", int'(mem[20]), 8'h11);

        // Reset during STORE.
        exp_eng = 1'b0; exp_cfg = 8'h3C; exp_seed = 8'h81;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_eng = 1'b0; cmd_cfg = 8'h3C; cmd_seed = 8'h81;
        cmd_addr = 8'd100; cmd_count = 8'd5;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rstmid_in_store", int'(mem_we), 1);
        w0 = writes_seen;
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_mem_we", int'(mem_we), 0);
        check("rstmid_done", int'(done), 0);
        check("rstmid_strobes", int'(eng_cfg_we) + int'(eng_seed_we) + int'(eng_step), 0);
        check("rstmid_sel", int'(eng_sel), 0);
        check("rstmid_hd", int'(hd_sum), 0);
        check("rstmid_addr", int'(mem_addr), 0);
        check("rstmid_wdata", int'(mem_wdata), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rstmid_no_write", writes_seen - w0, 0);
        check("rstmid_idle", int'(busy), 0);

        // Normal batch after reset.
        stub_tbl[0] = 8'hF0; stub_tbl[1] = 8'h0F;
        run_batch("post", 1'b1, 8'h5A, 8'hF0, 8'd50, 8'd2, 0, lat);
        check("post_m51_lit", int'(mem[51]), 8'h0F);
        check("post_hd_lit", int'(hd_sum), 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/prpg_batch_sequencer.md
Name: prpg_batch_sequencer

Overview:
- Command-driven controller that sequences one pattern engine, either the LFSR or the cellular automaton, through four steps: configure, seed, step, store.
- It writes each generated 8-bit pattern into the shared pattern memory.
- It replaces hand-written run/store/add_addr instruction sequences with a single batch command.
- It accumulates the Hamming distance between consecutive patterns, and sits between the instruction decoder and the engines/memory.

Parameters:
- MEM_DEPTH, 251, number of valid pattern-memory words; addresses >= MEM_DEPTH are illegal.
- HD_W, 11, width of the Hamming-distance accumulator (255 patterns x 8 bits = 2040 max, so no overflow).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  batch command present.
- cmd_ready  out  1  sequencer can accept; high only in IDLE.
- cmd_eng  in  1  engine select: 0=LFSR, 1=CA.
- cmd_cfg  in  8  LFSR taps (bits 6:0) or CA rule.
- cmd_seed  in  8  initial pattern.
- cmd_addr  in  8  first memory address.
- cmd_count  in  8  patterns to generate; 0 is legal.
- abort  in  1  terminate current batch.
- eng_sel  out  1  registered copy of cmd_eng.
- eng_cfg_we  out  1  one-cycle config strobe.
- eng_seed_we  out  1  one-cycle seed-load strobe.
- eng_step  out  1  one-cycle advance strobe.
- eng_cfg_data  out  8  config value.
- eng_seed_data  out  8  seed value.
- eng_q  in  8  current engine pattern; valid the cycle after eng_step or eng_seed_we.
- mem_we  out  1  memory write enable.
- mem_addr  out  8  write address.
- mem_wdata  out  8  write data.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at batch end.
- err  out  1  sticky: a write was suppressed because its address was out of range.
- hd_sum  out  HD_W  Hamming distance accumulated for the current batch.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All strobes, done, err, busy, mem_we, eng_sel are 0.
  - All data/address registers and hd_sum are 0.
  - Reset mid-batch discards the batch; no further writes occur.
- Command acceptance:
  - A command is accepted on the cycle where cmd_valid && cmd_ready.
  - All cmd_* fields are captured that cycle.
  - hd_sum and err clear that cycle.
- FSM states: IDLE, CONFIG, SEED, STEP, STORE, DONE.
- IDLE:
  - cmd_ready=1.
  - On accept, go to CONFIG.
- CONFIG:
  - eng_cfg_we=1; eng_cfg_data=captured cfg.
  - Next state SEED.
- SEED:
  - eng_seed_we=1; eng_seed_data=captured seed.
  - prev register <= seed.
  - If count==0, next state DONE; otherwise STEP.
- STEP:
  - eng_step=1.
  - Next state STORE.
- STORE:
  - mem_wdata=eng_q; mem_addr=addr.
  - mem_we=1 only if addr < MEM_DEPTH; otherwise the write is suppressed and err is set.
  - hd_sum += popcount(eng_q ^ prev); prev <= eng_q.
  - addr <= addr+1, wrapping 255 to 0.
  - count <= count-1.
  - If the new count is 0, next state DONE; otherwise STEP.
- DONE:
  - done=1 for one cycle, then IDLE.
- Timing:
  - Each pattern costs 2 cycles.
  - Accept to done pulse takes 3 + 2N cycles for count N, with N=0 giving 3.
- Strobes:
  - eng_cfg_we, eng_seed_we, eng_step and mem_we are each high for exactly one cycle per use.
  - No two of them are ever high in the same cycle.
- Abort:
  - Sampled in CONFIG, SEED and STEP; it forces DONE next cycle.
  - In STORE, the current write completes first, then DONE.
  - abort in IDLE is ignored.
  - hd_sum and err hold their values until the next accept.
- Simultaneous abort and cmd_valid in DONE: the command is not accepted until IDLE.
- cmd_valid held high across DONE: the next command is accepted on the first IDLE cycle (back-to-back batches, one idle cycle between).
- cmd_* fields are don't-care when cmd_valid=0.

Decomposition:
- Shared package prpg_pkg holds:
  - the state enum typedef;
  - ENG_LFSR/ENG_CA constants;
  - the opcode constants shared with the instruction decoder;
  - the pattern_t (8-bit) typedef.
- Sub-module popcount8, a combinational 8-bit population count.

Test Plan:
- CA batch: stub engine returns 0x01, 0x03, 0x07 after successive steps. Command eng=1, cfg=0x1E, seed=0x10, addr=240 (0xF0), count=3.
  - Expect writes M[240]=0x01, M[241]=0x03, M[242]=0x07.
  - Expect hd_sum=4, done 9 cycles after accept, err=0.
- count=0 with an LFSR command: cfg and seed strobes only, no eng_step, no mem_we, done 3 cycles after accept, hd_sum=0.
- Address boundary: addr=249, count=4, stub returns 0xFF each step.
  - Expect writes at 249 and 250; 251 and 252 are suppressed.
  - Expect err=1 and hd_sum = popcount(seed^0xFF).
- Wrap: addr=0xFF, count=2 writes addresses 255 (suppressed, err=1) then 0 (written).
- Abort: assert abort during the 2nd STEP of count=5. Expect exactly 1 write, done the next cycle, then IDLE with cmd_ready=1.
- Reset mid-batch: drop rst_n during STORE. Expect all outputs to be 0 immediately (async), no write after reset, and the next command to run normally.
